// File: rtl/ldl_fifo_pop_stream_v1.sv
// ldl_fifo_pop_stream_v1: pops an LDL FIFO read port and re-presents the words as a
// valid/ready stream through an RD_LAT+2 skid buffer. Optional drain: LDL_POP_FLUSH_EN.
`default_nettype none

module ldl_fifo_pop_stream_v1 #(
    parameter  int DW     = 8,
    parameter  int RD_LAT = 1,
    localparam int LW     = $clog2(RD_LAT + 3)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          empty,
    output logic          re,
    input  logic [DW-1:0] fifo_dout,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
`ifdef LDL_POP_FLUSH_EN
    input  logic          flush,
    output logic          flush_busy,
`endif
    output logic [LW-1:0] lvl
);

    localparam int DEPTH = RD_LAT + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int SW    = LW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic          run_q;

    logic [SW-1:0] w_inflight;
    logic          w_ret;
    logic          w_wr;
    logic          w_rd;
    logic          w_credit;
    logic          w_busy;
    logic          w_flush_go;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Issued-pop tracking: the bit leaving the pipe marks the cycle fifo_dout is valid.
    generate
        if (RD_LAT == 0) begin : g_lat0
            assign w_ret      = re;
            assign w_inflight = '0;
        end else begin : g_latn
            logic [RD_LAT-1:0] pipe_q, pipe_d;

            always_comb begin
                pipe_d    = pipe_q;
                pipe_d[0] = re;
                for (int i = 1; i < RD_LAT; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            always_comb begin
                w_inflight = '0;
                for (int i = 0; i < RD_LAT; i++) begin
                    w_inflight = w_inflight + SW'(pipe_q[i]);
                end
            end

            assign w_ret = pipe_q[RD_LAT-1];
        end
    endgenerate

`ifdef LDL_POP_FLUSH_EN
    logic busy_q, busy_d;

    assign w_flush_go = flush && !busy_q;
    assign w_busy     = busy_q;
    assign flush_busy = busy_q;

    always_comb begin
        busy_d = busy_q;
        if (w_flush_go) begin
            busy_d = 1'b1;
        end else if (busy_q && empty && (w_inflight == '0)) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end
`else
    assign w_flush_go = 1'b0;
    assign w_busy     = 1'b0;
`endif

    // Credits count words already buffered plus words still in the RAM pipe,
    // so a pop never needs to see o_ready and the buffer cannot overflow.
    assign w_credit = (({1'b0, lvl_q} + w_inflight) < SW'(DEPTH));
    assign re       = run_q && !empty && (w_busy || w_credit);

    assign o_valid  = (lvl_q != '0) && !w_busy;
    assign o_data   = mem_q[rp_q];
    assign lvl      = lvl_q;

    assign w_wr     = w_ret && !w_busy && !w_flush_go;
    assign w_rd     = o_valid && o_ready;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        lvl_d = lvl_q;
        if (w_flush_go) begin
            wp_d  = '0;
            rp_d  = '0;
            lvl_d = '0;
        end else begin
            if (w_wr) begin
                wp_d = ptr_inc(wp_q);
            end
            if (w_rd) begin
                rp_d = ptr_inc(rp_q);
            end
            case ({w_wr, w_rd})
                2'b10:   lvl_d = lvl_q + 1'b1;
                2'b01:   lvl_d = lvl_q - 1'b1;
                default: lvl_d = lvl_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
        end else begin
            run_q <= 1'b1;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            lvl_q <= lvl_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_wr) begin
            mem_q[wp_q] <= fifo_dout;
        end
    end

endmodule

`default_nettype wire
